irq_pending_latch: RTL and testbench

Interrupt request front end feeding the peripheral priority encoder. Synchronises raw asynchronous request lines and latches edge-triggered events as sticky pending bits. Applies a per-line enable mask and drives the masked pending vector straight into the encoder's input. The CPU clears an edge-mode event by handing back the encoder's output code on an acknowledge strobe.

---
 rtl/irq_pending_latch.sv | 82 ++++++++
 tb/tb_irq_pending_latch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Interrupt request front end: synchronises raw request lines, latches rising edges as sticky
// pending bits, applies the enable mask and drives the result into the priority encoder.
module irq_pending_latch #(
  parameter int unsigned         NUM_IRQS    = 16,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [NUM_IRQS-1:0] EDGE_MODE   = '1
) (
  input  logic                sysclk,
  input  logic                sysreset_n,
  input  logic [NUM_IRQS-1:0] irq_in,
  input  logic [NUM_IRQS-1:0] mask_in,
  input  logic                ack_valid,
  input  logic [15:0]         ack_code,
  output logic [NUM_IRQS-1:0] pending_out,
  output logic                irq_any,
  output logic [NUM_IRQS-1:0] overrun_out
);

  logic [NUM_IRQS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQS-1:0] hist_q;
  logic [NUM_IRQS-1:0] pend_q, pend_d;
  logic [NUM_IRQS-1:0] pending_q, pending_d;
  logic [NUM_IRQS-1:0] overrun_q, overrun_d;
  logic                irq_any_q, irq_any_d;

  logic [NUM_IRQS-1:0] sync_s;
  logic [NUM_IRQS-1:0] rise;
  logic [NUM_IRQS-1:0] ack_hit;

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~hist_q;

  // Codes at or beyond NUM_IRQS match no line, so they are ignored naturally.
  always_comb begin
    ack_hit = '0;
    for (int unsigned i = 0; i < NUM_IRQS; i++) begin
      ack_hit[i] = ack_valid && (32'(ack_code) == i);
    end
  end

  always_comb begin
    // Set wins over a same-cycle acknowledge: the old event is consumed, the new one held.
    pend_d    = (EDGE_MODE & (rise | (pend_q & ~ack_hit))) | (~EDGE_MODE & sync_s);
    overrun_d = EDGE_MODE & ~ack_hit & (overrun_q | (rise & pend_q));
    pending_d = pend_d & mask_in;
    irq_any_d = |pending_d;
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      hist_q    <= '0;
      pend_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      irq_any_q <= 1'b0;
    end else begin
      hist_q    <= sync_s;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      irq_any_q <= irq_any_d;
    end
  end

  assign pending_out = pending_q;
  assign overrun_out = overrun_q;
  assign irq_any     = irq_any_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: expected outputs are queued with a due cycle when the
// stimulus is driven and compared when that cycle arrives.
module tb_irq_pending_latch;

  logic        sysclk = 1'b0;
  logic        sysreset_n;
  logic [15:0] irq;
  logic [15:0] mask;
  logic        ack_valid;
  logic [15:0] ack_code;
  logic [15:0] pending_out;
  logic        irq_any;
  logic [15:0] overrun_out;

  typedef struct {
    int unsigned due;
    string       tag;
    logic [15:0] pend;
    logic        any;
    logic [15:0] ovr;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  irq_pending_latch #(
    .NUM_IRQS    (16),
    .SYNC_STAGES (2),
    .EDGE_MODE   (16'hFDFF)
  ) dut (
    .sysclk      (sysclk),
    .sysreset_n  (sysreset_n),
    .irq_in      (irq),
    .mask_in     (mask),
    .ack_valid   (ack_valid),
    .ack_code    (ack_code),
    .pending_out (pending_out),
    .irq_any     (irq_any),
    .overrun_out (overrun_out)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_now(input string tag, input logic [15:0] p, input logic a,
                           input logic [15:0] o);
    checks++;
    assert (pending_out === p) else begin
      errors++;
      $error("FAIL %s pending_out got %h want %h", tag, pending_out, p);
    end
    checks++;
    assert (irq_any === a) else begin
      errors++;
      $error("FAIL %s irq_any got %b want %b", tag, irq_any, a);
    end
    checks++;
    assert (overrun_out === o) else begin
      errors++;
      $error("FAIL %s overrun_out got %h want %h", tag, overrun_out, o);
    end
  endtask

  task automatic expect_in(input int unsigned n, input string tag, input logic [15:0] p,
                           input logic a, input logic [15:0] o);
    exp_t e;
    e.due  = cyc + n;
    e.tag  = tag;
    e.pend = p;
    e.any  = a;
    e.ovr  = o;
    sb.push_back(e);
  endtask

  task automatic tick();
    int i;
    @(posedge sysclk);
    #1;
    cyc++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        check_now(sb[i].tag, sb[i].pend, sb[i].any, sb[i].ovr);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick();
  endtask

  task automatic ack(input logic [15:0] code);
    ack_valid = 1'b1;
    ack_code  = code;
  endtask

  initial begin
    sysreset_n = 1'b0;
    irq        = '0;
    mask       = 16'hFFFF;
    ack_valid  = 1'b0;
    ack_code   = '0;
    #3;
    check_now("reset_state", 16'h0, 1'b0, 16'h0);
    ticks(2);
    sysreset_n = 1'b1;
    expect_in(3, "idle", 16'h0, 1'b0, 16'h0);
    ticks(3);

    // Basic edge capture and acknowledge on line 5.
    irq[5] = 1'b1;
    expect_in(2, "t1_pre", 16'h0, 1'b0, 16'h0);
    expect_in(3, "t1_edge", 16'h0020, 1'b1, 16'h0);
    ticks(3);
    irq[5] = 1'b0;
    ack(16'd5);
    expect_in(1, "t1_ack", 16'h0, 1'b0, 16'h0);
    tick();
    ack_valid = 1'b0;
    ticks(3);

    // Masked line keeps its event until unmasked.
    mask   = 16'hFFF7;
    irq[3] = 1'b1;
    expect_in(3, "t2_masked", 16'h0, 1'b0, 16'h0);
    ticks(2);
    irq[3] = 1'b0;
    ticks(3);
    mask = 16'hFFFF;
    expect_in(1, "t2_unmask", 16'h0008, 1'b1, 16'h0);
    tick();
    ack(16'd3);
    expect_in(1, "t2_clear", 16'h0, 1'b0, 16'h0);
    tick();
    ack_valid = 1'b0;
    ticks(2);

    // Second rise on line 7 coincides with its acknowledge.
    irq[7] = 1'b1;
    expect_in(3, "t3_first", 16'h0080, 1'b1, 16'h0);
    ticks(2);
    irq[7] = 1'b0;
    ticks(3);
    irq[7] = 1'b1;
    expect_in(2, "t3_pre", 16'h0080, 1'b1, 16'h0);
    expect_in(3, "t3_collide", 16'h0080, 1'b1, 16'h0);
    expect_in(4, "t3_hold", 16'h0080, 1'b1, 16'h0);
    ticks(2);
    ack(16'd7);
    tick();
    ack_valid = 1'b0;
    tick();
    irq[7] = 1'b0;
    ack(16'd7);
    expect_in(1, "t3_clear", 16'h0, 1'b0, 16'h0);
    tick();
    ack_valid = 1'b0;
    ticks(3);

    // Overrun on line 2.
    irq[2] = 1'b1;
    expect_in(3, "t4_first", 16'h0004, 1'b1, 16'h0);
    ticks(2);
    irq[2] = 1'b0;
    ticks(3);
    irq[2] = 1'b1;
    expect_in(2, "t4_pre_ovr", 16'h0004, 1'b1, 16'h0);
    expect_in(3, "t4_overrun", 16'h0004, 1'b1, 16'h0004);
    ticks(3);
    irq[2] = 1'b0;
    ack(16'd2);
    expect_in(1, "t4_clear", 16'h0, 1'b0, 16'h0);
    tick();
    ack_valid = 1'b0;
    ticks(3);

    // Level-mode line 9 ignores acknowledge.
    irq[9] = 1'b1;
    expect_in(3, "t5_level", 16'h0200, 1'b1, 16'h0);
    ticks(3);
    ack(16'd9);
    expect_in(1, "t5_ack_level", 16'h0200, 1'b1, 16'h0);
    tick();
    ack_valid = 1'b0;
    irq[9] = 1'b0;
    expect_in(2, "t5_level_hold", 16'h0200, 1'b1, 16'h0);
    expect_in(3, "t5_level_drop", 16'h0, 1'b0, 16'h0);
    ticks(3);

    // Out-of-range acknowledge codes change nothing.
    irq[1] = 1'b1;
    expect_in(3, "t6_line1", 16'h0002, 1'b1, 16'h0);
    ticks(3);
    ack(16'd16);
    expect_in(1, "t6_ack16", 16'h0002, 1'b1, 16'h0);
    tick();
    ack(16'd17);
    expect_in(1, "t6_ack17", 16'h0002, 1'b1, 16'h0);
    tick();
    ack_valid = 1'b0;
    irq[4] = 1'b1;
    expect_in(3, "t6_line4", 16'h0012, 1'b1, 16'h0);
    ticks(2);
    irq[4] = 1'b0;
    tick();

    // Reset mid-event with an acknowledge in flight; line 1 still high at release.
    ack(16'd4);
    sysreset_n = 1'b0;
    #1;
    check_now("t7_async_clear", 16'h0, 1'b0, 16'h0);
    ack_valid = 1'b0;
    ticks(2);
    sysreset_n = 1'b1;
    expect_in(2, "t7_pre", 16'h0, 1'b0, 16'h0);
    expect_in(3, "t7_return", 16'h0002, 1'b1, 16'h0);
    ticks(3);
    irq[1] = 1'b0;
    ticks(2);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain pending entries got %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
